// File: rtl/a_row_feeder.sv
// a_row_feeder: streams packed-row chunks from three synchronous memories to one row-by-vector consumer
module a_row_feeder #(
  parameter int element_width                   = 32,
  parameter int no_of_elements_in_p_emap_output = 8,
  parameter int no_of_elements_on_col_nos       = 20,
  parameter int col_nos_values_width            = 24,
  parameter int multiples_memory_value_width    = 3,
  parameter int memory_height                   = 1000,
  parameter int address_width                   = $clog2(memory_height) + 1
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic                                                      start,
  input  logic [31:0]                                               total,
  input  logic                                                      I_am_ready,
  input  logic [element_width*no_of_elements_in_p_emap_output-1:0]  memA_data,
  input  logic [no_of_elements_on_col_nos*col_nos_values_width-1:0] col_nos_data,
  input  logic [multiples_memory_value_width-1:0]                   multiples_data,
  output logic                                                      mem_rd_en,
  output logic [address_width-1:0]                                  mem_rd_address,
  output logic [element_width*no_of_elements_in_p_emap_output-1:0]  memA_output,
  output logic [no_of_elements_on_col_nos*col_nos_values_width-1:0] col_nos_output,
  output logic [multiples_memory_value_width-1:0]                   multiples_output,
  output logic                                                      you_can_read,
  output logic                                                      busy,
  output logic                                                      finish,
  output logic [31:0]                                               chunk_count
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, HOLD, SEND, DONE} state_t;
  state_t                   state_q, state_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [31:0]              total_q, total_d, count_q, count_d;
  logic                     last;
  assign last           = 32'(addr_q) == total_q - 32'd1;
  assign mem_rd_en      = state_q == FETCH;
  assign mem_rd_address = addr_q;
  assign you_can_read   = state_q == SEND;
  assign busy           = state_q != IDLE;
  assign finish         = state_q == DONE;
  assign chunk_count    = count_q;
  // next-state: one read per chunk, wait for the consumer in HOLD, commit the handoff in SEND
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    total_d = total_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (start) begin
        count_d = '0;
        addr_d  = '0;
        total_d = total;
        state_d = total != 32'd0 ? FETCH : DONE;
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD:    state_d = I_am_ready ? SEND : HOLD;
      SEND: begin
        count_d = count_q + 32'd1;
        addr_d  = last ? addr_q : addr_q + 1'b1;
        state_d = last ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      total_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      total_q <= total_d;
      count_q <= count_d;
    end
  end
  // output data registers: loaded only in CAPTURE so the chunk stays stable through the handoff
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memA_output      <= '0;
      col_nos_output   <= '0;
      multiples_output <= '0;
    end else if (state_q == CAPTURE) begin
      memA_output      <= memA_data;
      col_nos_output   <= col_nos_data;
      multiples_output <= multiples_data;
    end
  end
endmodule

// File: tb/tb_a_row_feeder.sv
// tb_a_row_feeder: directed scenario tests for a_row_feeder
module tb_a_row_feeder;
  localparam int AW = 11;
  localparam int DW = 256;
  localparam int CW = 480;
  logic          clk = 0;
  logic          reset = 0;
  logic          start = 0;
  logic [31:0]   total = 0;
  logic          I_am_ready = 1;
  logic [DW-1:0] memA_data = '0;
  logic [CW-1:0] col_nos_data = '0;
  logic [2:0]    multiples_data = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_address;
  logic [DW-1:0] memA_output;
  logic [CW-1:0] col_nos_output;
  logic [2:0]    multiples_output;
  logic          you_can_read, busy, finish;
  logic [31:0]   chunk_count;
  int checks = 0;
  int failures = 0;

  a_row_feeder dut (
    .clk(clk), .reset(reset), .start(start), .total(total), .I_am_ready(I_am_ready),
    .memA_data(memA_data), .col_nos_data(col_nos_data), .multiples_data(multiples_data),
    .mem_rd_en(mem_rd_en), .mem_rd_address(mem_rd_address), .memA_output(memA_output),
    .col_nos_output(col_nos_output), .multiples_output(multiples_output),
    .you_can_read(you_can_read), .busy(busy), .finish(finish), .chunk_count(chunk_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_a(input int k);
    logic [31:0] v;
    v = k;
    return {8{v}};
  endfunction
  function automatic logic [CW-1:0] exp_c(input int k);
    logic [23:0] v;
    v = k + 100;
    return {20{v}};
  endfunction
  function automatic logic [2:0] exp_m(input int k);
    return 3'(k % 8);
  endfunction

  always @(posedge clk) if (mem_rd_en) begin
    memA_data      <= exp_a(int'(mem_rd_address));
    col_nos_data   <= exp_c(int'(mem_rd_address));
    multiples_data <= exp_m(int'(mem_rd_address));
  end

  task automatic do_start(input logic [31:0] n);
    @(negedge clk);
    start = 1;
    total = n;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, mem_rd_en, you_can_read, finish} !== 4'b0 || chunk_count !== 0) begin
      failures++; $display("FAIL reset_hold ctl=%b count=%0d exp ctl=0000 count=0", {busy, mem_rd_en, you_can_read, finish}, chunk_count);
    end
    reset = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_rd_en, you_can_read, finish} !== 4'b0 || mem_rd_address !== 0 || memA_output !== 0 || col_nos_output !== 0 || multiples_output !== 0) begin
        failures++; $display("FAIL idle c=%0d ctl=%b addr=%0d exp all zero", c, {busy, mem_rd_en, you_can_read, finish}, mem_rd_address);
      end
    end
  endtask

  task automatic test_basic();
    I_am_ready = 1;
    do_start(3);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (mem_rd_en !== ((c % 4 == 1) && c <= 9)) begin
        failures++; $display("FAIL basic_rd_en c=%0d got=%b exp=%b", c, mem_rd_en, (c % 4 == 1) && c <= 9);
      end
      if ((c % 4 == 1) && c <= 9) begin
        checks++;
        if (mem_rd_address !== AW'((c - 1) / 4)) begin
          failures++; $display("FAIL basic_addr c=%0d got=%0d exp=%0d", c, mem_rd_address, (c - 1) / 4);
        end
      end
      checks++;
      if (you_can_read !== ((c % 4 == 0) && c <= 12)) begin
        failures++; $display("FAIL basic_strobe c=%0d got=%b exp=%b", c, you_can_read, (c % 4 == 0) && c <= 12);
      end
      if ((c % 4 == 0) && c <= 12) begin
        checks++;
        if (memA_output !== exp_a(c / 4 - 1) || col_nos_output !== exp_c(c / 4 - 1) || multiples_output !== exp_m(c / 4 - 1)) begin
          failures++; $display("FAIL basic_data c=%0d a=%h m=%0d exp chunk %0d", c, memA_output[31:0], multiples_output, c / 4 - 1);
        end
      end
      checks++;
      if (finish !== (c == 13) || busy !== (c <= 13)) begin
        failures++; $display("FAIL basic_finish_busy c=%0d got=%b%b exp=%b%b", c, finish, busy, c == 13, c <= 13);
      end
    end
    checks++;
    if (chunk_count !== 3) begin
      failures++; $display("FAIL basic_count got=%0d exp=3", chunk_count);
    end
  endtask

  task automatic test_backpressure();
    I_am_ready = 0;
    do_start(2);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 0;
      if (c == 10) I_am_ready = 1;
      checks++;
      if (you_can_read !== (c == 11 || c == 15) || finish !== (c == 16) || mem_rd_en !== (c == 1 || c == 12)) begin
        failures++; $display("FAIL bp_ctl c=%0d strobe=%b finish=%b rd=%b", c, you_can_read, finish, mem_rd_en);
      end
      if (c >= 3 && c <= 11) begin
        checks++;
        if (col_nos_output !== exp_c(0) || memA_output !== exp_a(0)) begin
          failures++; $display("FAIL bp_hold c=%0d col=%h exp=%h", c, col_nos_output[23:0], exp_c(0) & 24'hffffff);
        end
      end
      if (c == 15) begin
        checks++;
        if (memA_output !== exp_a(1) || multiples_output !== 3'd1) begin
          failures++; $display("FAIL bp_data2 a=%h m=%0d exp a=1 m=1", memA_output[31:0], multiples_output);
        end
      end
    end
    checks++;
    if (chunk_count !== 2) begin
      failures++; $display("FAIL bp_count got=%0d exp=2", chunk_count);
    end
  endtask

  task automatic test_total_zero();
    I_am_ready = 1;
    do_start(0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (busy !== (c == 1) || finish !== (c == 1) || mem_rd_en !== 0 || you_can_read !== 0) begin
        failures++; $display("FAIL zero c=%0d busy=%b fin=%b rd=%b str=%b exp busy=fin=%b", c, busy, finish, mem_rd_en, you_can_read, c == 1);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int strobes;
    strobes = 0;
    I_am_ready = 1;
    do_start(2);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = (c == 6);
      if (c == 6) total = 50;
      strobes += int'(you_can_read);
      checks++;
      if (you_can_read !== (c == 4 || c == 8) || finish !== (c == 9) || busy !== (c <= 9)) begin
        failures++; $display("FAIL swb c=%0d str=%b fin=%b busy=%b", c, you_can_read, finish, busy);
      end
    end
    checks++;
    if (strobes != 2 || chunk_count !== 2) begin
      failures++; $display("FAIL swb_count strobes=%0d count=%0d exp 2 2", strobes, chunk_count);
    end
  endtask

  task automatic test_reset_mid();
    I_am_ready = 1;
    do_start(5);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
    end
    reset = 0;
    #1;
    checks++;
    if ({busy, mem_rd_en, you_can_read, finish} !== 4'b0 || chunk_count !== 0 || col_nos_output !== 0 || mem_rd_address !== 0) begin
      failures++; $display("FAIL rst_mid ctl=%b count=%0d addr=%0d exp zero", {busy, mem_rd_en, you_can_read, finish}, chunk_count, mem_rd_address);
    end
    repeat (2) @(negedge clk);
    reset = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (you_can_read !== 0 || busy !== 0) begin
        failures++; $display("FAIL rst_quiet c=%0d str=%b busy=%b exp 0 0", c, you_can_read, busy);
      end
    end
    do_start(1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
      checks++;
      if (mem_rd_en !== (c == 1) || you_can_read !== (c == 4) || finish !== (c == 5)) begin
        failures++; $display("FAIL rst_restart c=%0d rd=%b str=%b fin=%b", c, mem_rd_en, you_can_read, finish);
      end
      if (c == 1) begin
        checks++;
        if (mem_rd_address !== 0) begin
          failures++; $display("FAIL rst_restart_addr got=%0d exp=0", mem_rd_address);
        end
      end
    end
    checks++;
    if (chunk_count !== 1) begin
      failures++; $display("FAIL rst_restart_count got=%0d exp=1", chunk_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_total_zero();
    test_start_while_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
